// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter
//
// Two-master arbiter for a single-port word memory (17-bit word address,
// 32-bit data, per-byte write enables). Master 0 is the CPU, master 1 is a
// second requester such as a DMA or IO engine.
//
// Arbitration is round-robin on ties. An owner may hold the port with its
// lock input for back-to-back transfers. The lock is forcibly released after
// LOCK_LIMIT consecutive locked transfers if the other master is waiting.
// The memory port is muxed combinationally from the current owner. Memory
// read data is combinational, and memory writes commit on the posedge.
//
// Parameters
//   LOCK_LIMIT      consecutive locked transfers before a forced release (>=1)
//   FIRST_PRIORITY  master that wins the first tie after reset (0 or 1)
//
// Ports
//   clock         in   system clock, all state changes on posedge
//   reset         in   synchronous, active-high
//   m0_req        in   master 0 request, held until acked
//   m0_lock       in   master 0 keeps ownership after this transfer
//   m0_address    in   master 0 word address (17 bits)
//   m0_write_en   in   master 0 byte-lane write enables, 0 = read
//   m0_data_in    in   master 0 write data
//   m0_ack        out  master 0 transfer completes at the next posedge
//   m1_*          same set for master 1
//   rd_data       out  memory read data broadcast to both masters
//   owner         out  00 idle, 01 master 0, 10 master 1 (registered)
//   mem_address   out  memory address
//   mem_write_en  out  memory byte-lane write enables
//   mem_data_in   out  memory write data
//   mem_data_out  in   memory read data
// ---------------------------------------------------------------------------
module memory_arbiter #(
    parameter int LOCK_LIMIT     = 4,
    parameter int FIRST_PRIORITY = 0
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_lock,
    input  logic [16:0] m0_address,
    input  logic [3:0]  m0_write_en,
    input  logic [31:0] m0_data_in,
    output logic        m0_ack,

    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic [16:0] m1_address,
    input  logic [3:0]  m1_write_en,
    input  logic [31:0] m1_data_in,
    output logic        m1_ack,

    output logic [31:0] rd_data,
    output logic [1:0]  owner,

    output logic [16:0] mem_address,
    output logic [3:0]  mem_write_en,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    // Counter is wide enough to hold LOCK_LIMIT itself; it saturates there.
    localparam int CNT_W = (LOCK_LIMIT < 2) ? 1 : $clog2(LOCK_LIMIT + 1);

    // State encoding doubles as the owner output encoding.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t            state_q, state_d;
    logic              last_served_q, last_served_d;
    logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;

    // View of the bus from the current owner's side, so that OWN0 and OWN1
    // share one set of transition rules.
    logic    own_sel;      // 1 when master 1 owns the port
    logic    own_req;
    logic    own_lock;
    logic    oth_req;
    state_t  other_state;
    logic    lock_room;    // another locked transfer still fits under the limit
    logic [CNT_W-1:0] lock_cnt_inc;

    always_comb begin
        own_sel     = (state_q == OWN1);
        own_req     = own_sel ? m1_req  : m0_req;
        own_lock    = own_sel ? m1_lock : m0_lock;
        oth_req     = own_sel ? m0_req  : m1_req;
        other_state = own_sel ? OWN0    : OWN1;
    end

    assign lock_room    = (({1'b0, lock_cnt_q} + 1'b1) < (CNT_W + 1)'(LOCK_LIMIT));
    assign lock_cnt_inc = (lock_cnt_q == CNT_W'(LOCK_LIMIT)) ? lock_cnt_q
                                                             : lock_cnt_q + 1'b1;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            // The first tie goes to FIRST_PRIORITY, so pretend the other
            // master was served last.
            last_served_q <= (FIRST_PRIORITY == 0) ? 1'b1 : 1'b0;
            lock_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            lock_cnt_q    <= lock_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        lock_cnt_d    = lock_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (m0_req && m1_req) begin
                    state_d = last_served_q ? OWN0 : OWN1;
                end else if (m0_req) begin
                    state_d = OWN0;
                end else if (m1_req) begin
                    state_d = OWN1;
                end
            end

            OWN0, OWN1: begin
                if (own_req) begin
                    // ack equals req while owning, so this edge completes
                    // a transfer.
                    last_served_d = own_sel;
                    if (own_lock && (lock_room || !oth_req)) begin
                        lock_cnt_d = lock_cnt_inc;
                    end else begin
                        lock_cnt_d = '0;
                        state_d    = oth_req ? other_state : IDLE;
                    end
                end else begin
                    // Owner withdrew its request without a transfer.
                    lock_cnt_d = '0;
                    state_d    = oth_req ? other_state : IDLE;
                end
            end

            default: begin
                state_d    = IDLE;
                lock_cnt_d = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Memory port mux and acks
    // -----------------------------------------------------------------------
    // Everything is forced to zero during reset, so a reset that lands in
    // the middle of a transfer cannot write any byte at that edge.
    always_comb begin
        m0_ack       = 1'b0;
        m1_ack       = 1'b0;
        mem_address  = '0;
        mem_write_en = '0;
        mem_data_in  = '0;

        if (!reset) begin
            unique case (state_q)
                OWN0: begin
                    m0_ack       = m0_req;
                    mem_address  = m0_address;
                    mem_write_en = m0_write_en & {4{m0_req}};
                    mem_data_in  = m0_data_in;
                end
                OWN1: begin
                    m1_ack       = m1_req;
                    mem_address  = m1_address;
                    mem_write_en = m1_write_en & {4{m1_req}};
                    mem_data_in  = m1_data_in;
                end
                default: begin
                    m0_ack = 1'b0;
                    m1_ack = 1'b0;
                end
            endcase
        end
    end

    assign rd_data = mem_data_out;
    assign owner   = state_q;

    a_single_ack: assert property (@(posedge clock) disable iff (reset)
                                   !(m0_ack && m1_ack));

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_req, m0_lock, m1_req, m1_lock;
    logic [16:0] m0_address, m1_address;
    logic [3:0]  m0_write_en, m1_write_en;
    logic [31:0] m0_data_in, m1_data_in;
    logic        m0_ack, m1_ack;
    logic [31:0] rd_data;
    logic [1:0]  owner;
    logic [16:0] mem_address;
    logic [3:0]  mem_write_en;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    always #5 clock = ~clock;

    memory_arbiter #(
        .LOCK_LIMIT     (4),
        .FIRST_PRIORITY (0)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .m0_req       (m0_req),
        .m0_lock      (m0_lock),
        .m0_address   (m0_address),
        .m0_write_en  (m0_write_en),
        .m0_data_in   (m0_data_in),
        .m0_ack       (m0_ack),
        .m1_req       (m1_req),
        .m1_lock      (m1_lock),
        .m1_address   (m1_address),
        .m1_write_en  (m1_write_en),
        .m1_data_in   (m1_data_in),
        .m1_ack       (m1_ack),
        .rd_data      (rd_data),
        .owner        (owner),
        .mem_address  (mem_address),
        .mem_write_en (mem_write_en),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    // Word memory behind the arbiter: combinational read, byte-lane write on
    // posedge. Lane b covers data bits [8b+7:8b], so write_en 4'b0011 touches
    // the two low-order bytes.
    logic [31:0] mem [0:131071] = '{default: 32'h0};
    logic        preload = 1'b0;

    assign mem_data_out = mem[mem_address];

    always @(posedge clock) begin
        if (preload) mem[17'h00010] <= 32'h12345678;
        for (int b = 0; b < 4; b++) begin
            if (mem_write_en[b]) mem[mem_address][8*b +: 8] <= mem_data_in[8*b +: 8];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic clear_inputs();
        m0_req = 1'b0; m0_lock = 1'b0; m0_address = '0; m0_write_en = '0; m0_data_in = '0;
        m1_req = 1'b0; m1_lock = 1'b0; m1_address = '0; m1_write_en = '0; m1_data_in = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    int n0, n1, first_m1, m0_before, both;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- reset state ----------------
        clear_inputs();
        reset   = 1'b1;
        preload = 1'b1;
        @(negedge clock);
        tick();
        preload    = 1'b0;
        m0_req     = 1'b1;
        m0_address = 17'h1ABCD;
        m0_write_en = 4'hF;
        #1;
        check("rst_owner", 32'(owner), 32'h0);
        check("rst_m0_ack", 32'(m0_ack), 32'h0);
        check("rst_we", 32'(mem_write_en), 32'h0);
        check("rst_addr", 32'(mem_address), 32'h0);
        tick();
        #1;
        check("rst_owner_held", 32'(owner), 32'h0);
        clear_inputs();
        reset = 1'b0;

        // ---------------- 1: single read by m0 ----------------
        m0_req     = 1'b1;
        m0_address = 17'h10;
        #1;
        check("t1_idle_owner", 32'(owner), 32'h0);
        check("t1_idle_ack", 32'(m0_ack), 32'h0);
        tick();
        #1;
        check("t1_owner", 32'(owner), 32'h1);
        check("t1_m0_ack", 32'(m0_ack), 32'h1);
        check("t1_m1_ack", 32'(m1_ack), 32'h0);
        check("t1_rd_data", rd_data, 32'h12345678);
        check("t1_mem_addr", 32'(mem_address), 32'h10);
        check("t1_mem_we", 32'(mem_write_en), 32'h0);
        m0_req = 1'b0;
        tick();
        #1;
        check("t1_back_idle", 32'(owner), 32'h0);

        // ---------------- 2: simultaneous writes, round-robin ----------------
        do_reset();
        m0_req = 1'b1; m0_address = 17'h30; m0_write_en = 4'hF; m0_data_in = 32'hA5A5A5A5;
        m1_req = 1'b1; m1_address = 17'h31; m1_write_en = 4'hF; m1_data_in = 32'h11223344;
        #1;
        check("t2_idle_owner", 32'(owner), 32'h0);
        tick();
        #1;
        check("t2_first_owner", 32'(owner), 32'h1);
        check("t2_m0_ack", 32'(m0_ack), 32'h1);
        check("t2_m1_wait", 32'(m1_ack), 32'h0);
        check("t2_addr0", 32'(mem_address), 32'h30);
        check("t2_we0", 32'(mem_write_en), 32'hF);
        tick();
        m0_req = 1'b0;
        #1;
        check("t2_handoff_owner", 32'(owner), 32'h2);
        check("t2_m1_ack", 32'(m1_ack), 32'h1);
        check("t2_m0_noack", 32'(m0_ack), 32'h0);
        check("t2_addr1", 32'(mem_address), 32'h31);
        tick();
        m1_req = 1'b0;
        #1;
        check("t2_idle_after", 32'(owner), 32'h0);
        check("t2_mem30", mem[17'h30], 32'hA5A5A5A5);
        check("t2_mem31", mem[17'h31], 32'h11223344);
        // second tie must go to m0 (m1 was served last)
        m0_req = 1'b1; m0_write_en = 4'h0;
        m1_req = 1'b1; m1_write_en = 4'h0;
        tick();
        #1;
        check("t2_tie2_owner", 32'(owner), 32'h1);
        check("t2_tie2_rd", rd_data, 32'hA5A5A5A5);
        tick();
        m0_req = 1'b0;
        #1;
        check("t2_tie2_m1", 32'(m1_ack), 32'h1);
        check("t2_tie2_rd1", rd_data, 32'h11223344);
        tick();
        clear_inputs();

        // ---------------- 3: partial byte write by m1 ----------------
        m1_req = 1'b1; m1_address = 17'h20; m1_write_en = 4'b0011; m1_data_in = 32'hDEADBEEF;
        tick();
        #1;
        check("t3_owner", 32'(owner), 32'h2);
        check("t3_we", 32'(mem_write_en), 32'h3);
        tick();
        clear_inputs();
        #1;
        check("t3_mem20", mem[17'h20], 32'h0000BEEF);

        // ---------------- 4: lock limit with m1 waiting ----------------
        do_reset();
        m0_req = 1'b1; m0_lock = 1'b1; m0_address = 17'h40;
        m1_req = 1'b1; m1_address = 17'h41;
        n0 = 0; n1 = 0; first_m1 = -1; m0_before = -1; both = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (m0_ack) n0++;
            if (m1_ack) n1++;
            if (m1_ack && first_m1 < 0) begin
                first_m1  = c;
                m0_before = n0;
            end
            if (m0_ack && m1_ack) both++;
            tick();
            if (n0 >= 10) m0_req = 1'b0;
            if (first_m1 >= 0) m1_req = 1'b0;
        end
        #1;
        check("t4_m0_acks_before_m1", 32'(m0_before), 32'd4);
        check("t4_m1_wait_cycles", 32'(first_m1), 32'd5);
        check("t4_m0_total", 32'(n0), 32'd10);
        check("t4_m1_total", 32'(n1), 32'd1);
        check("t4_both_acks", 32'(both), 32'd0);
        check("t4_end_idle", 32'(owner), 32'h0);
        clear_inputs();

        // ---------------- 5: reset during an m1 write ----------------
        do_reset();
        m1_req = 1'b1; m1_address = 17'h60; m1_write_en = 4'hF; m1_data_in = 32'hFFFFFFFF;
        tick();
        #1;
        check("t5_pre_owner", 32'(owner), 32'h2);
        check("t5_pre_ack", 32'(m1_ack), 32'h1);
        reset = 1'b1;
        #1;
        check("t5_we_gated", 32'(mem_write_en), 32'h0);
        check("t5_ack_gated", 32'(m1_ack), 32'h0);
        check("t5_addr_zero", 32'(mem_address), 32'h0);
        check("t5_data_zero", mem_data_in, 32'h0);
        tick();
        #1;
        check("t5_owner_idle", 32'(owner), 32'h0);
        check("t5_mem60", mem[17'h60], 32'h0);
        reset = 1'b0;
        clear_inputs();

        // ---------------- 6: owner withdraws request ----------------
        do_reset();
        m0_req = 1'b1; m0_lock = 1'b1; m0_address = 17'h50; m0_write_en = 4'hF;
        m0_data_in = 32'hCAFEF00D;
        tick();
        tick();
        tick();
        #1;
        check("t6_locked_owner", 32'(owner), 32'h1);
        tick();
        m0_req = 1'b0; m0_data_in = 32'hBADBAD00;
        #1;
        check("t6_wd_ack", 32'(m0_ack), 32'h0);
        check("t6_wd_we", 32'(mem_write_en), 32'h0);
        tick();
        #1;
        check("t6_idle", 32'(owner), 32'h0);
        check("t6_mem50", mem[17'h50], 32'hCAFEF00D);
        // a fresh lock run must get the full LOCK_LIMIT transfers
        m0_req = 1'b1; m0_write_en = 4'h0;
        tick();
        m1_req = 1'b1; m1_address = 17'h51;
        n0 = 0; first_m1 = -1; m0_before = -1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (m0_ack) n0++;
            if (m1_ack && first_m1 < 0) begin
                first_m1  = c;
                m0_before = n0;
            end
            tick();
            if (first_m1 >= 0) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
        end
        #1;
        check("t6_lockcnt_cleared", 32'(m0_before), 32'd4);
        check("t6_end_idle", 32'(owner), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
